// File: rtl/quiz_responder_n_pkg.sv
// rtl/quiz_responder_n_pkg.sv - shared states, widths and score saturation helpers
package quiz_responder_n_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_LOCKED = 2'd2,
    ST_OVER   = 2'd3
  } state_t;

  localparam int COUNT_W = 8;

  // Increment clamped at max_v
  function automatic int sat_inc(input int v, input int max_v);
    return (v >= max_v) ? max_v : v + 1;
  endfunction

  // Decrement clamped at zero
  function automatic int sat_dec(input int v);
    return (v <= 0) ? 0 : v - 1;
  endfunction

endpackage

// File: rtl/quiz_responder_n_prio_enc.sv
// rtl/quiz_responder_n_prio_enc.sv - lowest-index-wins priority encoder
module prio_enc_n #(
  parameter int N   = 8,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  output logic           valid,
  output logic [IDW-1:0] id
);

  // Scan from the top down so the lowest set index is the last one written
  always_comb begin
    valid = |req;
    id    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) id = IDW'(i);
    end
  end

endmodule

// File: rtl/quiz_responder_n.sv
// rtl/quiz_responder_n.sv - N-player quiz responder: arming, lock-out, scoring, fouls, timeouts
module quiz_responder_n
  import quiz_responder_n_pkg::*;
#(
  parameter int N_PLAYERS  = 8,
  parameter int SCORE_W    = 4,
  parameter int INIT_SCORE = 5,
  parameter int WIN_SCORE  = 9,
  parameter int TICKS_SEC  = 1000,
  parameter int RESP_SEC   = 10,
  parameter int ANS_SEC    = 20,
  parameter int BEEP_CYC   = 200,
  parameter int FOUL_EN    = 1,
  parameter int IDW        = $clog2(N_PLAYERS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_PLAYERS-1:0]         press,
  input  logic                         host_start,
  input  logic                         judge_ok,
  input  logic                         judge_bad,
  output logic                         lock_valid,
  output logic [IDW-1:0]               lock_id,
  output logic [N_PLAYERS-1:0]         lock_onehot,
  output logic [N_PLAYERS*SCORE_W-1:0] scores,
  output logic [COUNT_W-1:0]           countdown,
  output logic [N_PLAYERS-1:0]         foul,
  output logic                         winner_valid,
  output logic [IDW-1:0]               winner_id,
  output logic                         sound,
  output logic [1:0]                   state
);

  localparam int SMAX = (1 << SCORE_W) - 1;
  localparam int PW   = (TICKS_SEC > 1) ? $clog2(TICKS_SEC) : 1;
  localparam int BW   = $clog2(BEEP_CYC + 1);

  state_t               state_q, state_d;
  logic [N_PLAYERS-1:0] press_q;
  logic                 start_q, ok_q, bad_q;
  logic [SCORE_W-1:0]   score_q [N_PLAYERS];
  logic [SCORE_W-1:0]   score_d [N_PLAYERS];
  logic [N_PLAYERS-1:0] foul_q, foul_d;
  logic [IDW-1:0]       lock_id_q, lock_id_d;
  logic [IDW-1:0]       winner_id_q, winner_id_d;
  logic [PW-1:0]        presc_q, presc_d;
  logic [COUNT_W-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]        beep_q, beep_d;
  logic                 beep_ev;
  logic                 tick, expire, win_hit;
  logic [SCORE_W-1:0]   upd;

  logic [N_PLAYERS-1:0] press_edge;
  logic                 start_edge, ok_edge, bad_edge;
  logic                 pe_valid;
  logic [IDW-1:0]       pe_id;

  assign press_edge = press & ~press_q;
  assign start_edge = host_start & ~start_q;
  assign ok_edge    = judge_ok & ~ok_q & ~(judge_bad & ~bad_q);
  assign bad_edge   = judge_bad & ~bad_q & ~(judge_ok & ~ok_q);

  prio_enc_n #(.N(N_PLAYERS), .IDW(IDW)) u_lock (
    .req   (press_edge),
    .valid (pe_valid),
    .id    (pe_id)
  );

  // Next-state, countdown and scoring decisions
  always_comb begin
    state_d     = state_q;
    score_d     = score_q;
    foul_d      = foul_q;
    lock_id_d   = lock_id_q;
    winner_id_d = winner_id_q;
    presc_d     = presc_q;
    cnt_d       = cnt_q;
    beep_ev     = 1'b0;
    win_hit     = 1'b0;
    upd         = '0;
    tick        = (presc_q == PW'(TICKS_SEC - 1));
    expire      = tick && (cnt_q == COUNT_W'(1));

    if (state_q == ST_ARMED || state_q == ST_LOCKED) begin
      if (tick) begin
        presc_d = '0;
        cnt_d   = cnt_q - COUNT_W'(1);
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          state_d = ST_ARMED;
          cnt_d   = COUNT_W'(RESP_SEC);
          presc_d = '0;
          foul_d  = '0;
        end else if (FOUL_EN != 0) begin
          for (int k = 0; k < N_PLAYERS; k++) begin
            if (press_edge[k]) begin
              upd        = SCORE_W'(sat_dec(int'(score_q[k])));
              score_d[k] = upd;
              foul_d[k]  = 1'b1;
              beep_ev    = 1'b1;
              if (!win_hit && int'(upd) == WIN_SCORE) begin
                win_hit     = 1'b1;
                winner_id_d = IDW'(k);
              end
            end
          end
          if (win_hit) state_d = ST_OVER;
        end
      end
      ST_ARMED: begin
        if (pe_valid) begin
          state_d   = ST_LOCKED;
          lock_id_d = pe_id;
          cnt_d     = COUNT_W'(ANS_SEC);
          presc_d   = '0;
          beep_ev   = 1'b1;
        end else if (expire) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          presc_d = '0;
          beep_ev = 1'b1;
        end
      end
      ST_LOCKED: begin
        if (ok_edge || bad_edge || expire) begin
          if (ok_edge) upd = SCORE_W'(sat_inc(int'(score_q[lock_id_q]), SMAX));
          else         upd = SCORE_W'(sat_dec(int'(score_q[lock_id_q])));
          score_d[lock_id_q] = upd;
          cnt_d              = '0;
          presc_d            = '0;
          lock_id_d          = '0;
          if (int'(upd) == WIN_SCORE) begin
            state_d     = ST_OVER;
            winner_id_d = lock_id_q;
            beep_ev     = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        presc_d = '0;
      end
    endcase
  end

  // Buzzer length counter, restarted by every new beep event
  always_comb begin
    beep_d = beep_q;
    if (beep_ev)              beep_d = BW'(BEEP_CYC);
    else if (beep_q != '0)    beep_d = beep_q - BW'(1);
  end

  // State and input-history registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      press_q     <= '0;
      start_q     <= 1'b0;
      ok_q        <= 1'b0;
      bad_q       <= 1'b0;
      foul_q      <= '0;
      lock_id_q   <= '0;
      winner_id_q <= '0;
      presc_q     <= '0;
      cnt_q       <= '0;
      beep_q      <= '0;
      for (int k = 0; k < N_PLAYERS; k++) score_q[k] <= SCORE_W'(INIT_SCORE);
    end else begin
      state_q     <= state_d;
      press_q     <= press;
      start_q     <= host_start;
      ok_q        <= judge_ok;
      bad_q       <= judge_bad;
      foul_q      <= foul_d;
      lock_id_q   <= lock_id_d;
      winner_id_q <= winner_id_d;
      presc_q     <= presc_d;
      cnt_q       <= cnt_d;
      beep_q      <= beep_d;
      score_q     <= score_d;
    end
  end

  for (genvar g = 0; g < N_PLAYERS; g++) begin : g_scores
    assign scores[g*SCORE_W +: SCORE_W] = score_q[g];
  end

  assign state        = state_q;
  assign lock_valid   = (state_q == ST_LOCKED);
  assign lock_id      = lock_id_q;
  assign lock_onehot  = lock_valid ? (N_PLAYERS'(1) << lock_id_q) : '0;
  assign countdown    = cnt_q;
  assign foul         = foul_q;
  assign winner_valid = (state_q == ST_OVER);
  assign winner_id    = winner_id_q;
  assign sound        = (beep_q != '0);

endmodule

// File: tb/tb_quiz_responder_n.sv
// tb/tb_quiz_responder_n.sv - directed self-checking bench for quiz_responder_n
module tb_quiz_responder_n;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  press = '0;
  logic        host_start = 1'b0, judge_ok = 1'b0, judge_bad = 1'b0;
  logic        lock_valid, winner_valid, sound;
  logic [2:0]  lock_id, winner_id;
  logic [7:0]  lock_onehot, foul, countdown;
  logic [31:0] scores;
  logic [1:0]  state;

  int tests = 0;
  int fails = 0;
  int exp_score [8];

  quiz_responder_n #(.N_PLAYERS(8), .TICKS_SEC(10)) dut (
    .clk(clk), .rst(rst), .press(press), .host_start(host_start),
    .judge_ok(judge_ok), .judge_bad(judge_bad), .lock_valid(lock_valid),
    .lock_id(lock_id), .lock_onehot(lock_onehot), .scores(scores),
    .countdown(countdown), .foul(foul), .winner_valid(winner_valid),
    .winner_id(winner_id), .sound(sound), .state(state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_packed();
    logic [31:0] r;
    for (int k = 0; k < 8; k++) r[k*4 +: 4] = 4'(exp_score[k]);
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b0; tick(); rst = 1'b1;
    for (int k = 0; k < 8; k++) exp_score[k] = 5;
    tests++; if (scores !== 32'h5555_5555) begin fails++; $display("FAIL reset_scores got %h want 55555555", scores); end
    tests++; if (state !== 2'd0) begin fails++; $display("FAIL reset_state got %0d want 0", state); end
    tests++; if (sound !== 1'b0) begin fails++; $display("FAIL reset_sound got %b want 0", sound); end
    tests++; if (lock_valid !== 1'b0) begin fails++; $display("FAIL reset_lock got %b want 0", lock_valid); end
    tests++; if (countdown !== 8'd0 || foul !== 8'h00) begin fails++; $display("FAIL reset_misc got cd=%0d foul=%h want 0/00", countdown, foul); end
  endtask

  task automatic test_lock_priority();
    host_start = 1'b1; tick(); host_start = 1'b0;
    tests++; if (state !== 2'd1 || countdown !== 8'd10) begin fails++; $display("FAIL arm got st=%0d cd=%0d want 1/10", state, countdown); end
    press = 8'h28; tick(); press = 8'h00;
    tests++; if (state !== 2'd2 || lock_valid !== 1'b1) begin fails++; $display("FAIL lock_state got st=%0d lv=%b want 2/1", state, lock_valid); end
    tests++; if (lock_id !== 3'd3) begin fails++; $display("FAIL lock_id got %0d want 3", lock_id); end
    tests++; if (lock_onehot !== 8'h08) begin fails++; $display("FAIL lock_onehot got %h want 08", lock_onehot); end
    tests++; if (sound !== 1'b1 || countdown !== 8'd20) begin fails++; $display("FAIL lock_beep got snd=%b cd=%0d want 1/20", sound, countdown); end
    repeat (199) tick();
    tests++; if (sound !== 1'b1 || state !== 2'd2 || countdown !== 8'd1) begin fails++; $display("FAIL beep_199 got snd=%b st=%0d cd=%0d want 1/2/1", sound, state, countdown); end
    tick();
    exp_score[3] = 4;
    tests++; if (sound !== 1'b0) begin fails++; $display("FAIL beep_200 got %b want 0", sound); end
    tests++; if (state !== 2'd0 || scores !== exp_packed()) begin fails++; $display("FAIL ans_timeout got st=%0d sc=%h want 0/%h", state, scores, exp_packed()); end
  endtask

  task automatic test_judge();
    host_start = 1'b1; tick(); host_start = 1'b0;
    press = 8'h08; tick(); press = 8'h00;
    judge_ok = 1'b1; judge_bad = 1'b1; tick();
    tests++; if (state !== 2'd2 || scores !== exp_packed()) begin fails++; $display("FAIL judge_both got st=%0d sc=%h want 2/%h", state, scores, exp_packed()); end
    judge_ok = 1'b0; judge_bad = 1'b0; tick();
    judge_ok = 1'b1; tick(); judge_ok = 1'b0;
    exp_score[3] = 5;
    tests++; if (scores !== exp_packed() || state !== 2'd0) begin fails++; $display("FAIL judge_ok got st=%0d sc=%h want 0/%h", state, scores, exp_packed()); end
    tests++; if (lock_valid !== 1'b0 || lock_onehot !== 8'h00) begin fails++; $display("FAIL judge_unlock got lv=%b oh=%h want 0/00", lock_valid, lock_onehot); end
    tick();
  endtask

  task automatic test_foul();
    press = 8'h04; tick(); press = 8'h00;
    exp_score[2] = 4;
    tests++; if (foul !== 8'h04 || scores !== exp_packed()) begin fails++; $display("FAIL foul_one got f=%h sc=%h want 04/%h", foul, scores, exp_packed()); end
    tests++; if (sound !== 1'b1) begin fails++; $display("FAIL foul_beep got %b want 1", sound); end
    tick();
    repeat (5) begin press = 8'h04; tick(); press = 8'h00; tick(); end
    exp_score[2] = 0;
    tests++; if (scores !== exp_packed() || foul !== 8'h04) begin fails++; $display("FAIL foul_floor got f=%h sc=%h want 04/%h", foul, scores, exp_packed()); end
    press = 8'h03; tick(); press = 8'h00;
    exp_score[0] = 4; exp_score[1] = 4;
    tests++; if (scores !== exp_packed() || foul !== 8'h07) begin fails++; $display("FAIL foul_multi got f=%h sc=%h want 07/%h", foul, scores, exp_packed()); end
    repeat (200) tick();
    tests++; if (sound !== 1'b0) begin fails++; $display("FAIL beep_end got %b want 0", sound); end
  endtask

  task automatic test_resp_timeout();
    host_start = 1'b1; tick(); host_start = 1'b0;
    tests++; if (foul !== 8'h00 || state !== 2'd1) begin fails++; $display("FAIL arm_clear got f=%h st=%0d want 00/1", foul, state); end
    repeat (99) tick();
    tests++; if (state !== 2'd1 || countdown !== 8'd1) begin fails++; $display("FAIL resp_99 got st=%0d cd=%0d want 1/1", state, countdown); end
    tick();
    tests++; if (state !== 2'd0 || countdown !== 8'd0 || sound !== 1'b1) begin fails++; $display("FAIL resp_expire got st=%0d cd=%0d snd=%b want 0/0/1", state, countdown, sound); end
    tests++; if (scores !== exp_packed()) begin fails++; $display("FAIL resp_scores got %h want %h", scores, exp_packed()); end
  endtask

  task automatic round_ok_p1();
    host_start = 1'b1; tick(); host_start = 1'b0; tick();
    press = 8'h02; tick(); press = 8'h00; tick();
    judge_ok = 1'b1; tick(); judge_ok = 1'b0; tick();
  endtask

  task automatic test_win();
    repeat (4) round_ok_p1();
    exp_score[1] = 8;
    tests++; if (scores !== exp_packed() || state !== 2'd0) begin fails++; $display("FAIL pre_win got st=%0d sc=%h want 0/%h", state, scores, exp_packed()); end
    round_ok_p1();
    exp_score[1] = 9;
    tests++; if (state !== 2'd3 || winner_valid !== 1'b1) begin fails++; $display("FAIL win_state got st=%0d wv=%b want 3/1", state, winner_valid); end
    tests++; if (winner_id !== 3'd1 || scores !== exp_packed()) begin fails++; $display("FAIL win_id got id=%0d sc=%h want 1/%h", winner_id, scores, exp_packed()); end
    tests++; if (sound !== 1'b1) begin fails++; $display("FAIL win_beep got %b want 1", sound); end
    host_start = 1'b1; press = 8'hFF; judge_bad = 1'b1; tick();
    host_start = 1'b0; press = 8'h00; judge_bad = 1'b0; tick();
    tests++; if (state !== 2'd3 || scores !== exp_packed() || foul !== 8'h00) begin fails++; $display("FAIL over_hold got st=%0d sc=%h f=%h want 3/%h/00", state, scores, foul, exp_packed()); end
    rst = 1'b0; tick(); rst = 1'b1;
    tests++; if (state !== 2'd0 || scores !== 32'h5555_5555 || winner_valid !== 1'b0 || winner_id !== 3'd0) begin fails++; $display("FAIL over_reset got st=%0d sc=%h wv=%b wid=%0d want 0/55555555/0/0", state, scores, winner_valid, winner_id); end
  endtask

  initial begin
    tick();
    test_reset();
    test_lock_priority();
    test_judge();
    test_foul();
    test_resp_timeout();
    test_win();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
